// File: rtl/segment_frame_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : segment_frame_scheduler
// Desc    : Per-frame sequencer for the LiDAR segment refiner: label-table clear,
//           voxel accumulation, pipeline drain and size-filtered cluster readout.
// Options : SEG_SCHED_ABORT_EN adds an 'abort' input that cancels a frame.
// Rev     : 1.0 - initial release
//==============================================================================
module segment_frame_scheduler #(
    parameter int CLEAR_DEPTH  = 32768,
    parameter int DRAIN_CYCLES = 3,
    parameter int IDX_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SEG_SCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic              frame_start,
    input  logic [15:0]       min_size,
    input  logic              vox_valid,
    output logic              vox_ready,
    input  logic              vox_last,
    input  logic [14:0]       vox_label,
    input  logic [9:0]        vox_x,
    input  logic [9:0]        vox_y,
    input  logic [9:0]        vox_z,
    output logic              dp_valid,
    output logic [14:0]       dp_label,
    output logic [9:0]        dp_x,
    output logic [9:0]        dp_y,
    output logic [9:0]        dp_z,
    output logic              dp_clear_en,
    output logic [14:0]       dp_clear_addr,
    input  logic [12:0]       dp_used,
    output logic              dp_rd_en,
    output logic [IDX_W-1:0]  dp_rd_addr,
    input  logic [75:0]       dp_rd_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [75:0]       rec_data,
    output logic [12:0]       cluster_count,
    output logic              busy,
    output logic              done
);

    localparam int                    c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int                    c_USED_W     = IDX_W + 1;
    localparam logic [14:0]           c_CLEAR_LAST = 15'(CLEAR_DEPTH - 1);
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_USED_W-1:0]   c_USED_MAX   = c_USED_W'(1) << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_ACCUM    = 3'd2,
        S_DRAIN    = 3'd3,
        S_RD_ISSUE = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_EMIT     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_min_size;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [c_USED_W-1:0]    r_used;
    logic [c_USED_W-1:0]    r_ptr;

    logic                   w_abort;
    logic                   w_vox_hs;
    logic                   w_keep;
    logic                   w_advance;
    logic                   w_more;
    logic [c_USED_W-1:0]    w_ptr_next;
    logic [c_USED_W-1:0]    w_used_sat;

`ifdef SEG_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_vox_hs   = vox_valid && vox_ready;
    assign w_keep     = dp_rd_data[75:60] >= r_min_size;
    assign w_ptr_next = r_ptr + c_USED_W'(1);
    assign w_more     = w_ptr_next < r_used;
    // A read entry is finished either by rejection in RD_WAIT or by the record handshake.
    assign w_advance  = ((r_state == S_RD_WAIT) && !w_keep) ||
                        ((r_state == S_EMIT) && rec_ready);

    // The cluster memory holds at most 2^IDX_W entries; larger counts are clipped.
    always_comb begin
        w_used_sat = c_USED_W'(dp_used);
        if (int'(dp_used) > (1 << IDX_W)) begin
            w_used_sat = c_USED_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_min_size    <= 16'd0;
            r_drain_cnt   <= '0;
            r_used        <= '0;
            r_ptr         <= '0;
            vox_ready     <= 1'b0;
            dp_valid      <= 1'b0;
            dp_label      <= 15'd0;
            dp_x          <= 10'd0;
            dp_y          <= 10'd0;
            dp_z          <= 10'd0;
            dp_clear_en   <= 1'b0;
            dp_clear_addr <= 15'd0;
            dp_rd_en      <= 1'b0;
            dp_rd_addr    <= '0;
            rec_valid     <= 1'b0;
            rec_data      <= 76'd0;
            cluster_count <= 13'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (w_abort) begin
            // Cancel without a done pulse; cluster_count keeps its last value.
            r_state       <= S_IDLE;
            vox_ready     <= 1'b0;
            dp_valid      <= 1'b0;
            dp_clear_en   <= 1'b0;
            dp_clear_addr <= 15'd0;
            dp_rd_en      <= 1'b0;
            rec_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            dp_valid <= 1'b0;
            dp_rd_en <= 1'b0;
            done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_min_size    <= min_size;
                        cluster_count <= 13'd0;
                        dp_clear_en   <= 1'b1;
                        dp_clear_addr <= 15'd0;
                        busy          <= 1'b1;
                        r_state       <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (dp_clear_addr == c_CLEAR_LAST) begin
                        dp_clear_en   <= 1'b0;
                        dp_clear_addr <= 15'd0;
                        vox_ready     <= 1'b1;
                        r_state       <= S_ACCUM;
                    end else begin
                        dp_clear_addr <= dp_clear_addr + 15'd1;
                    end
                end

                S_ACCUM: begin
                    if (w_vox_hs) begin
                        dp_valid <= 1'b1;
                        dp_label <= vox_label;
                        dp_x     <= vox_x;
                        dp_y     <= vox_y;
                        dp_z     <= vox_z;
                        if (vox_last) begin
                            vox_ready   <= 1'b0;
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_used <= w_used_sat;
                        r_ptr  <= '0;
                        if (w_used_sat == '0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            dp_rd_en   <= 1'b1;
                            dp_rd_addr <= '0;
                            r_state    <= S_RD_ISSUE;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_DRAIN_W'(1);
                    end
                end

                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (w_keep) begin
                        rec_valid <= 1'b1;
                        rec_data  <= dp_rd_data;
                        r_state   <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid     <= 1'b0;
                        cluster_count <= cluster_count + 13'd1;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_advance) begin
                r_ptr <= w_ptr_next;
                if (w_more) begin
                    dp_rd_en   <= 1'b1;
                    dp_rd_addr <= w_ptr_next[IDX_W-1:0];
                    r_state    <= S_RD_ISSUE;
                end else begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segment_frame_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : tb_segment_frame_scheduler
// Desc    : Randomized self-checking bench; models the cluster memory and the
//           expected filtered record stream from the frame rules.
// Rev     : 1.0 - initial release
//==============================================================================
module tb_segment_frame_scheduler;

    localparam int c_CLEAR_DEPTH = 16;
    localparam int c_DRAIN       = 3;
    localparam int c_IDX_W       = 12;
    localparam int c_ENTRIES     = 1 << c_IDX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [15:0]       min_size;
    logic              vox_valid;
    logic              vox_ready;
    logic              vox_last;
    logic [14:0]       vox_label;
    logic [9:0]        vox_x, vox_y, vox_z;
    logic              dp_valid;
    logic [14:0]       dp_label;
    logic [9:0]        dp_x, dp_y, dp_z;
    logic              dp_clear_en;
    logic [14:0]       dp_clear_addr;
    logic [12:0]       dp_used;
    logic              dp_rd_en;
    logic [c_IDX_W-1:0] dp_rd_addr;
    logic [75:0]       dp_rd_data;
    logic              rec_valid;
    logic              rec_ready;
    logic [75:0]       rec_data;
    logic [12:0]       cluster_count;
    logic              busy;
    logic              done;
`ifdef SEG_SCHED_ABORT_EN
    logic              abort;
`endif

    segment_frame_scheduler #(
        .CLEAR_DEPTH  (c_CLEAR_DEPTH),
        .DRAIN_CYCLES (c_DRAIN),
        .IDX_W        (c_IDX_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
`ifdef SEG_SCHED_ABORT_EN
        .abort         (abort),
`endif
        .frame_start   (frame_start),
        .min_size      (min_size),
        .vox_valid     (vox_valid),
        .vox_ready     (vox_ready),
        .vox_last      (vox_last),
        .vox_label     (vox_label),
        .vox_x         (vox_x),
        .vox_y         (vox_y),
        .vox_z         (vox_z),
        .dp_valid      (dp_valid),
        .dp_label      (dp_label),
        .dp_x          (dp_x),
        .dp_y          (dp_y),
        .dp_z          (dp_z),
        .dp_clear_en   (dp_clear_en),
        .dp_clear_addr (dp_clear_addr),
        .dp_used       (dp_used),
        .dp_rd_en      (dp_rd_en),
        .dp_rd_addr    (dp_rd_addr),
        .dp_rd_data    (dp_rd_data),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_data      (rec_data),
        .cluster_count (cluster_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cluster memory model: one-cycle read latency, junk on cycles without a read.
    logic [75:0] mem [c_ENTRIES];
    always @(posedge clk) begin
        if (dp_rd_en) dp_rd_data <= mem[dp_rd_addr];
        else          dp_rd_data <= 76'({$urandom, $urandom, $urandom});
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation state collected by the monitor, consumed by the frame tasks.
    int          start_cyc, ready_rise, first_clr, clr_cnt, dpv_cnt;
    int          done_cnt, done_cyc, first_rd, last_hs;
    logic [75:0] got_q[$];
    bit          p_hs, p_stall, p_done, p_start;
    logic [44:0] p_fields;
    logic [75:0] p_rec;

    always @(negedge clk) begin
        if (rst) begin
            p_hs = 0; p_stall = 0; p_done = 0; p_start = 0;
        end else begin
            if (p_start) check_eq("busy_rise", busy, 1);
            if (p_done)  check_eq("busy_fall", busy, 0);
            if (dp_clear_en) begin
                if (clr_cnt == 0) first_clr = cyc;
                check_eq("clear_addr", dp_clear_addr, clr_cnt);
                clr_cnt++;
            end
            if (vox_ready && ready_rise < 0) ready_rise = cyc;
            if (dp_valid || p_hs) check_eq("dp_valid_latency", dp_valid, p_hs);
            if (p_hs) check_eq("dp_fields", {dp_label, dp_x, dp_y, dp_z}, p_fields);
            if (dp_valid) dpv_cnt++;
            if (p_stall) begin
                check_eq("rec_hold_valid", rec_valid, 1);
                check_eq("rec_hold_data", rec_data, p_rec);
            end
            if (dp_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                check_eq("rd_while_rec_valid", rec_valid, 0);
            end
            if (rec_valid && rec_ready) got_q.push_back(rec_data);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (vox_valid && vox_ready && vox_last) last_hs = cyc;
            p_start  = frame_start && !busy;
            if (p_start) start_cyc = cyc;
            p_hs     = vox_valid && vox_ready;
            p_fields = {vox_label, vox_x, vox_y, vox_z};
            p_stall  = rec_valid && !rec_ready;
            p_rec    = rec_data;
            p_done   = done;
        end
    end

    int rr_mode       = 0;
    bit stall_pending = 0;

    initial begin
        rec_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_pending && rec_valid) begin
                rec_ready = 1'b0;
                repeat (10) begin @(posedge clk); #1; end
                stall_pending = 0;
            end
            rec_ready = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic fill_mem(input logic [15:0] msz);
        for (int i = 0; i < c_ENTRIES; i++) begin
            logic [15:0] sz;
            case ($urandom_range(0, 3))
                0:       sz = msz;
                1:       sz = msz - 16'd1;
                default: sz = 16'($urandom);
            endcase
            mem[i] = {sz, 60'({$urandom, $urandom})};
        end
    endtask

    task automatic start_frame(input int used_cnt, input logic [15:0] msz);
        int k;
        clr_cnt = 0; ready_rise = -1; first_clr = -1; dpv_cnt = 0;
        done_cnt = 0; done_cyc = -1; first_rd = -1; last_hs = -1;
        got_q.delete();
        dp_used     = 13'(used_cnt);
        min_size    = msz;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        min_size    = 16'($urandom);
        k = 0;
        while (ready_rise < 0 && k < 200) begin @(negedge clk); #1; k++; end
        check_eq("vox_ready_rise", ready_rise - start_cyc, c_CLEAR_DEPTH + 1);
        check_eq("clear_first", first_clr - start_cyc, 1);
        check_eq("clear_len", clr_cnt, c_CLEAR_DEPTH);
        @(posedge clk); #1;
    endtask

    task automatic send_voxels(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                vox_valid   = 1'b0;
                vox_last    = 1'($urandom_range(0, 1));
                frame_start = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
            vox_valid = 1'b1;
            vox_last  = with_last && (i == n - 1);
            vox_label = 15'($urandom);
            vox_x     = 10'($urandom);
            vox_y     = 10'($urandom);
            vox_z     = 10'($urandom);
            @(posedge clk); #1;
        end
        vox_valid = 1'b0;
        vox_last  = 1'b0;
    endtask

    task automatic finish_frame(input int nvox, input int used_cnt, input logic [15:0] msz);
        logic [75:0] exp_q[$];
        int lim, k, n;
        lim = (used_cnt > c_ENTRIES) ? c_ENTRIES : used_cnt;
        for (int i = 0; i < lim; i++)
            if (mem[i][75:60] >= msz) exp_q.push_back(mem[i]);
        k = 0;
        while (done_cnt == 0 && k < 40000) begin @(negedge clk); #1; k++; end
        repeat (3) begin @(negedge clk); #1; end
        check_eq("done_pulses", done_cnt, 1);
        check_eq("dp_valid_pulses", dpv_cnt, nvox);
        if (lim == 0) check_eq("done_latency", done_cyc - last_hs, c_DRAIN + 1);
        else          check_eq("drain_latency", first_rd - last_hs, c_DRAIN + 1);
        check_eq("rec_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq("rec_data", got_q[i], exp_q[i]);
        check_eq("cluster_count", cluster_count, exp_q.size());
        check_eq("idle_after_done", {busy, vox_ready, rec_valid}, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobes"}, {vox_ready, dp_valid, dp_clear_en, dp_rd_en, rec_valid, busy, done}, 0);
        check_eq({tag, "_dp_fields"}, {dp_label, dp_x, dp_y, dp_z}, 0);
        check_eq({tag, "_addrs"}, {dp_clear_addr, dp_rd_addr}, 0);
        check_eq({tag, "_rec_data"}, rec_data, 0);
        check_eq({tag, "_cluster_count"}, cluster_count, 0);
    endtask

    initial begin
        int nv, used, sat_used;
        logic [15:0] ms;
        rst = 1'b1; frame_start = 1'b0; min_size = 16'd0; vox_valid = 1'b0; vox_last = 1'b0;
        vox_label = 15'd0; vox_x = 10'd0; vox_y = 10'd0; vox_z = 10'd0; dp_used = 13'd0;
`ifdef SEG_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Directed frame: sizes {8,7,20,1}, threshold 8 -> entries 0 and 2.
        fill_mem(16'd8);
        mem[0][75:60] = 16'd8; mem[1][75:60] = 16'd7; mem[2][75:60] = 16'd20; mem[3][75:60] = 16'd1;
        rr_mode = 0;
        start_frame(4, 16'd8);
        send_voxels(5, 1);
        finish_frame(5, 4, 16'd8);

        // Same frame with a 10-cycle consumer stall on the first record.
        stall_pending = 1;
        start_frame(4, 16'd8);
        send_voxels(5, 1);
        finish_frame(5, 4, 16'd8);

        // Empty cluster memory.
        start_frame(0, 16'd3);
        send_voxels(2, 1);
        finish_frame(2, 0, 16'd3);

        // Randomized frames with random backpressure.
        rr_mode = 1;
        for (int f = 0; f < 4; f++) begin
            nv   = $urandom_range(1, 8);
            used = $urandom_range(1, 40);
            ms   = 16'($urandom);
            fill_mem(ms);
            start_frame(used, ms);
            send_voxels(nv, 1);
            finish_frame(nv, used, ms);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        // Used count above the memory depth saturates at 2^IDX_W reads.
        rr_mode  = 0;
        sat_used = 5000;
        ms       = 16'hC000;
        fill_mem(ms);
        start_frame(sat_used, ms);
        send_voxels(3, 1);
        finish_frame(3, sat_used, ms);

        // Reset in the middle of accumulation, then a complete fresh frame.
        start_frame(2, 16'd0);
        send_voxels(3, 0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
        @(posedge clk); #1;
        fill_mem(16'd100);
        start_frame(6, 16'd100);
        send_voxels(4, 1);
        finish_frame(4, 6, 16'd100);

`ifdef SEG_SCHED_ABORT_EN
        begin
            int k;
            logic [12:0] cc_before;
            cc_before = cluster_count;
            for (int i = 0; i < 4; i++) mem[i][75:60] = 16'hFFFF;
            stall_pending = 1;
            start_frame(4, 16'd1);
            send_voxels(2, 1);
            k = 0;
            while (!rec_valid && k < 100) begin @(posedge clk); #1; k++; end
            check_eq("abort_emit_reached", rec_valid, 1);
            cc_before = cluster_count;
            abort = 1'b1;
            @(negedge clk);
            check_eq("abort_rec_valid", rec_valid, 0);
            check_eq("abort_busy", busy, 0);
            @(posedge clk); #1;
            abort = 1'b0;
            repeat (12) begin @(posedge clk); #1; end
            check_eq("abort_no_done", done_cnt, 0);
            check_eq("abort_count_kept", cluster_count, cc_before);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_frame_scheduler.md
# segment_frame_scheduler

Per-frame sequencer for the LiDAR segment refiner datapath. Runs each frame through clear of the label table, voxel accumulation with a ready/valid handshake, pipeline drain, and size-filtered readout of the cluster property memory. The readout is delivered as a backpressured record stream. The block sits between the voxel clustering stage and the downstream object builder, and owns every control input of the refiner datapath.

## Interface
- CLEAR_DEPTH, 32768: label-table entries cleared per frame.
- DRAIN_CYCLES, 3: datapath pipeline depth waited after the last voxel.
- IDX_W, 12: cluster memory address width.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- frame_start  input  1  pulse; starts a frame, honoured only in IDLE.
- min_size  input  16  size threshold, sampled on the accepted frame_start.
- vox_valid  input  1  voxel present.
- vox_ready  output  1  voxel accepted when vox_valid && vox_ready.
- vox_last  input  1  marks the final voxel of the frame.
- vox_label  input  15  cluster ID.
- vox_x, vox_y, vox_z  input  10 each  voxel coordinates.
- dp_valid  output  1  voxel strobe to the datapath.
- dp_label, dp_x, dp_y, dp_z  output  15/10/10/10  registered voxel fields.
- dp_clear_en  output  1  clears label table entry dp_clear_addr and resets the datapath free index.
- dp_clear_addr  output  15  entry being cleared.
- dp_used  input  13  number of clusters allocated by the datapath.
- dp_rd_en  output  1  cluster memory read strobe.
- dp_rd_addr  output  IDX_W  read address.
- dp_rd_data  input  76  {size[75:60], min_x, max_x, min_y, max_y, min_z, max_z}, valid one cycle after dp_rd_en.
- rec_valid  output  1  filtered record present.
- rec_ready  input  1  consumer accepts.
- rec_data  output  76  record, same packing as dp_rd_data.
- cluster_count  output  13  records delivered in the current/last frame.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, RD_ISSUE, RD_WAIT, EMIT, DONE.
- IDLE:
  - On frame_start: latch min_size, zero cluster_count, go to CLEAR.
  - frame_start in any other state is ignored.
- CLEAR:
  - dp_clear_en=1 and dp_clear_addr=0..CLEAR_DEPTH-1, one per cycle.
  - After the last address, go to ACCUM.
- ACCUM:
  - vox_ready=1.
  - Each handshake registers the voxel onto dp_* with dp_valid=1 for exactly one cycle.
  - A handshake with vox_last=1 goes to DRAIN.
  - vox_ready=0 in every other state.
- DRAIN:
  - Count DRAIN_CYCLES cycles, then latch dp_used into an internal used register and reset the read pointer to 0.
  - If used==0, go to DONE; otherwise go to RD_ISSUE.
- RD_ISSUE: dp_rd_en=1 with dp_rd_addr=pointer; go to RD_WAIT.
- RD_WAIT: capture dp_rd_data.
  - If size >= latched min_size (unsigned compare), go to EMIT.
  - Otherwise increment the pointer, then go to RD_ISSUE if pointer+1 < used, else DONE.
- EMIT:
  - rec_valid=1 with rec_data stable until rec_ready.
  - On the handshake: cluster_count+1, advance the pointer, leave as in RD_WAIT.
- DONE: done=1 for one cycle, then IDLE. cluster_count holds until the next accepted frame_start.
- The used register saturates reads at 2^IDX_W entries; dp_used > 4096 is treated as 4096.
- rst in any state: immediate return to IDLE; any partial frame is discarded.

## Timing
- Reset values: vox_ready, dp_valid, dp_clear_en, dp_rd_en, rec_valid, busy, done = 0; dp_label, dp_x/y/z, dp_clear_addr, dp_rd_addr, rec_data, cluster_count = 0.
- All outputs are registered.
- frame_start accepted at cycle t:
  - CLEAR covers cycles t+1..t+CLEAR_DEPTH.
  - vox_ready rises at t+CLEAR_DEPTH+1.
- Voxel handshake at cycle c: dp_valid at c+1.
- vox_last handshake at cycle c: the used latch happens at c+DRAIN_CYCLES+1.
- Per entry: 2 cycles if rejected; 3 cycles minimum if emitted (RD_ISSUE, RD_WAIT, EMIT), plus rec_ready stall.
- busy rises the cycle after the accepted frame_start and falls the cycle after done.

## Configuration
- SEG_SCHED_ABORT_EN defined: adds port abort, input, 1 bit.
  - abort=1 in any non-IDLE state returns to IDLE the next cycle.
  - All strobes and rec_valid drop at once, even mid-handshake.
  - done is not pulsed and cluster_count keeps its value.
  - abort has priority over frame_start and vox_last in the same cycle.
- Not defined: no abort port; a frame is only terminated by vox_last or rst.

## Test plan
- CLEAR_DEPTH=16, frame_start pulse: dp_clear_en high exactly 16 cycles, addresses 0..15; vox_ready rises on the 17th cycle after the pulse.
- 5 voxels, the last with vox_last, vox_valid gapped: five dp_valid pulses, each one cycle after its handshake; DRAIN lasts 3 cycles.
- dp_used=4, memory sizes {8,7,20,1}, min_size=8, rec_ready=1: records for addresses 0 and 2 only, cluster_count=2, done pulses once.
- Same frame with rec_ready held low 10 cycles during the first EMIT: rec_data stable throughout; no further dp_rd_en until the handshake.
- dp_used=0: done exactly one cycle after the DRAIN count ends, no rec_valid, cluster_count=0.
- rst asserted mid-ACCUM, then a new frame_start: all outputs 0 during reset; the next frame runs the full CLEAR again. With SEG_SCHED_ABORT_EN, abort during EMIT gives rec_valid=0 next cycle and no done pulse.
